// File: rtl/common_fifo_ram_1w1r_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : common_fifo_ram_1w1r_ctl_pkg
// Purpose  : Shared constants and helpers for the common RAM-based FIFO
//            family (depth derivation, legal parameter ranges).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package common_fifo_ram_1w1r_ctl_pkg;

  localparam int unsigned FIFO_DEPTH_LOG2_MIN = 1;
  localparam int unsigned FIFO_DEPTH_LOG2_MAX = 8;

  // Entry count for a given log2 depth.
  function automatic int unsigned fifo_depth(input int unsigned depth_log2);
    return 32'd1 << depth_log2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/common_dffram_2a1w1r.sv
`default_nettype none
// ============================================================================
// Module   : common_dffram_2a1w1r
// Purpose  : Flop-based RAM with separate write and read addresses, one
//            synchronous write port and one combinational read port.
//            Contents are cleared by the asynchronous reset.
// Ports    : clk, resetn      - clock / async active-low reset
//            we, waddr, wdata - write port (rising edge)
//            raddr, rdata     - combinational read port
// Revision : 1.0 - initial release
// ============================================================================
module common_dffram_2a1w1r #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned c_words = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:c_words-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(c_words); i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/common_fifo_ptr_ctl.sv
`default_nettype none
// ============================================================================
// Module   : common_fifo_ptr_ctl
// Purpose  : Pointer, occupancy, flag and sticky-error logic for a
//            single-clock FIFO. Storage lives outside this block.
// Ports    : clk, resetn            - clock / async active-low reset
//            wen, ren               - push / pop requests
//            flush, err_clr         - synchronous clear of pointers / errors
//            push_ok                - push accepted this cycle (RAM write)
//            waddr, raddr           - RAM addresses (pointer low bits)
//            fifo_empty/full, almost_empty/full, count - status
//            err_overflow, err_underflow               - sticky errors
// Revision : 1.0 - initial release
// ============================================================================
module common_fifo_ptr_ctl
  import common_fifo_ram_1w1r_ctl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2     = 2,
  parameter int unsigned ALMOST_FULL_THRESH  = 3,
  parameter int unsigned ALMOST_EMPTY_THRESH = 1,
  parameter int unsigned PASS_WHEN_FULL      = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wen,
  input  logic                       ren,
  input  logic                       flush,
  input  logic                       err_clr,
  output logic                       push_ok,
  output logic [FIFO_DEPTH_LOG2-1:0] waddr,
  output logic [FIFO_DEPTH_LOG2-1:0] raddr,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [FIFO_DEPTH_LOG2:0]   count,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  localparam int unsigned            c_pw   = FIFO_DEPTH_LOG2 + 1;
  localparam logic [FIFO_DEPTH_LOG2:0] c_af = c_pw'(ALMOST_FULL_THRESH);
  localparam logic [FIFO_DEPTH_LOG2:0] c_ae = c_pw'(ALMOST_EMPTY_THRESH);
  localparam logic                   c_pass = (PASS_WHEN_FULL != 0);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [FIFO_DEPTH_LOG2:0] r_wptr;
  logic [FIFO_DEPTH_LOG2:0] r_rptr;
  logic                     r_err_overflow;
  logic                     r_err_underflow;
  logic                     w_pop_ok;
  logic                     w_push_ok;
  logic [FIFO_DEPTH_LOG2:0] w_count;
  logic                     w_empty;
  logic                     w_full;

  assign w_count = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FIFO_DEPTH_LOG2-1:0] == r_rptr[FIFO_DEPTH_LOG2-1:0]) &&
                   (r_wptr[FIFO_DEPTH_LOG2] != r_rptr[FIFO_DEPTH_LOG2]);

  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can land there.
  assign w_pop_ok  = ren & ~w_empty;
  assign w_push_ok = wen & (~w_full | (c_pass & w_pop_ok));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Clear first, set afterwards: a set in the same cycle wins. A flush
  // cycle does not record errors for the requests it discards.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (err_clr) begin
        r_err_overflow  <= 1'b0;
        r_err_underflow <= 1'b0;
      end
      if (!flush) begin
        if (wen & ~w_push_ok) r_err_overflow  <= 1'b1;
        if (ren & w_empty)    r_err_underflow <= 1'b1;
      end
    end
  end

  assign push_ok       = w_push_ok & ~flush;
  assign waddr         = r_wptr[FIFO_DEPTH_LOG2-1:0];
  assign raddr         = r_rptr[FIFO_DEPTH_LOG2-1:0];
  assign fifo_empty    = w_empty;
  assign fifo_full     = w_full;
  assign almost_empty  = (w_count <= c_ae);
  assign almost_full   = (w_count >= c_af);
  assign count         = w_count;
  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;

endmodule
`default_nettype wire

// File: rtl/common_fifo_ram_1w1r_ctl.sv
`default_nettype none
// ============================================================================
// Module   : common_fifo_ram_1w1r_ctl
// Purpose  : Single-clock RAM FIFO, 1 write / 1 read port, show-ahead
//            read data, occupancy count, almost flags, optional
//            write-through-when-full, synchronous flush, sticky errors.
// Ports    : clk, resetn    - clock / async active-low reset
//            din, wen       - push data / request
//            dout, ren      - head entry (show-ahead) / pop request
//            flush, err_clr - synchronous clear of contents / error flags
//            fifo_empty, fifo_full, almost_empty, almost_full, count
//            err_overflow, err_underflow
// Revision : 1.0 - initial release
// ============================================================================
module common_fifo_ram_1w1r_ctl
  import common_fifo_ram_1w1r_ctl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2     = 2,
  parameter int unsigned FIFO_WIDTH          = 8,
  parameter int unsigned ALMOST_FULL_THRESH  = 3,
  parameter int unsigned ALMOST_EMPTY_THRESH = 1,
  parameter int unsigned PASS_WHEN_FULL      = 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [FIFO_WIDTH-1:0]  din,
  input  logic                   wen,
  output logic [FIFO_WIDTH-1:0]  dout,
  input  logic                   ren,
  input  logic                   flush,
  input  logic                   err_clr,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic                   almost_empty,
  output logic                   almost_full,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                   err_overflow,
  output logic                   err_underflow
);

  localparam int unsigned c_depth = fifo_depth(FIFO_DEPTH_LOG2);

  // Parameter legality, reported at elaboration.
  if (FIFO_DEPTH_LOG2 < FIFO_DEPTH_LOG2_MIN || FIFO_DEPTH_LOG2 > FIFO_DEPTH_LOG2_MAX) begin : g_chk_depth
    $error("common_fifo_ram_1w1r_ctl: FIFO_DEPTH_LOG2 out of range 1..8");
  end
  if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > c_depth) begin : g_chk_af
    $error("common_fifo_ram_1w1r_ctl: ALMOST_FULL_THRESH out of range 1..DEPTH");
  end
  if (ALMOST_EMPTY_THRESH > c_depth - 1) begin : g_chk_ae
    $error("common_fifo_ram_1w1r_ctl: ALMOST_EMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic                       w_push_ok;
  logic [FIFO_DEPTH_LOG2-1:0] w_waddr;
  logic [FIFO_DEPTH_LOG2-1:0] w_raddr;

  common_fifo_ptr_ctl #(
    .FIFO_DEPTH_LOG2     (FIFO_DEPTH_LOG2),
    .ALMOST_FULL_THRESH  (ALMOST_FULL_THRESH),
    .ALMOST_EMPTY_THRESH (ALMOST_EMPTY_THRESH),
    .PASS_WHEN_FULL      (PASS_WHEN_FULL)
  ) u_ptr_ctl (
    .clk           (clk),
    .resetn        (resetn),
    .wen           (wen),
    .ren           (ren),
    .flush         (flush),
    .err_clr       (err_clr),
    .push_ok       (w_push_ok),
    .waddr         (w_waddr),
    .raddr         (w_raddr),
    .fifo_empty    (fifo_empty),
    .fifo_full     (fifo_full),
    .almost_empty  (almost_empty),
    .almost_full   (almost_full),
    .count         (count),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  // Read port follows the registered read pointer, so dout is show-ahead
  // with no same-cycle path from din.
  common_dffram_2a1w1r #(
    .ADDR_W (FIFO_DEPTH_LOG2),
    .DATA_W (FIFO_WIDTH)
  ) u_ram (
    .clk    (clk),
    .resetn (resetn),
    .we     (w_push_ok),
    .waddr  (w_waddr),
    .wdata  (din),
    .raddr  (w_raddr),
    .rdata  (dout)
  );

endmodule
`default_nettype wire
